cover_toggle_collector: RTL and testbench

COVER_TOGGLE_COLLECTOR -- requirements
Module: cover_toggle_collector

---
 rtl/cover_toggle_collector.sv | 132 +++++++++++++
 tb/tb_cover_toggle_collector.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cover_toggle_collector.sv
// Collects toggle-cover hits and reports each newly covered point's global index exactly once per clear.
// Latency: 1 cycle from first hit to out_valid. Backpressure: out_index holds until out_ready; later hits queue in pending.
// Comment: all state resets asynchronously when reset is low.
module cover_toggle_collector #(
    parameter int unsigned COVER_WIDTH = 4,
    parameter logic [63:0] COVER_INDEX = 64'd0,
    parameter int unsigned COVER_TOTAL = 8940,
    localparam int unsigned HW = $clog2(COVER_WIDTH + 1),
    localparam int unsigned IW = (COVER_WIDTH > 1) ? $clog2(COVER_WIDTH) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [COVER_WIDTH-1:0] valid,
    input  logic                   clear,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [63:0]            out_index,
    output logic [HW-1:0]          hit_count,
    output logic                   all_covered
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam logic [COVER_WIDTH-1:0] ONE = COVER_WIDTH'(1);

    state_t                 state_q;
    logic [COVER_WIDTH-1:0] seen_q;
    logic [COVER_WIDTH-1:0] seen_d;
    logic [COVER_WIDTH-1:0] pending_q;
    logic [HW-1:0]          hit_q;
    logic [HW-1:0]          hit_d;
    logic                   out_valid_q;
    logic [63:0]            out_index_q;
    logic                   all_q;

    logic [COVER_WIDTH-1:0] new_hits;
    logic [COVER_WIDTH-1:0] cand;
    logic [COVER_WIDTH-1:0] rest;
    logic [IW-1:0]          low_idx;
    logic [63:0]            load_index;

    function automatic logic [HW-1:0] popcnt(input logic [COVER_WIDTH-1:0] v);
        logic [HW-1:0] c;
        c = '0;
        for (int i = 0; i < int'(COVER_WIDTH); i++) begin
            c = c + HW'(v[i]);
        end
        return c;
    endfunction

    // A clear discards both the queued points and anything hit in the same cycle.
    always_comb begin
        new_hits = clear ? '0 : (valid & ~seen_q);
        cand     = clear ? '0 : (pending_q | new_hits);
        seen_d   = clear ? '0 : (seen_q | valid);
        hit_d    = clear ? '0 : (hit_q + popcnt(new_hits));
        low_idx  = '0;
        for (int i = int'(COVER_WIDTH) - 1; i >= 0; i--) begin
            if (cand[i]) begin
                low_idx = IW'(i);
            end
        end
        rest       = cand & ~(ONE << low_idx);
        load_index = COVER_INDEX + 64'(low_idx);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            seen_q      <= '0;
            pending_q   <= '0;
            hit_q       <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            all_q       <= 1'b0;
        end else begin
            seen_q <= seen_d;
            hit_q  <= hit_d;
            all_q  <= &seen_d;
            case (state_q)
                IDLE: begin
                    if (|cand) begin
                        state_q     <= PRESENT;
                        out_valid_q <= 1'b1;
                        out_index_q <= load_index;
                        pending_q   <= rest;
                    end else begin
                        pending_q   <= '0;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        if (|cand) begin
                            out_index_q <= load_index;
                            pending_q   <= rest;
                        end else begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            pending_q   <= '0;
                        end
                    end else begin
                        pending_q <= cand;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    pending_q   <= '0;
                end
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_index   = out_index_q;
    assign hit_count   = hit_q;
    assign all_covered = all_q;

    // A presented index must not move or vanish until it is accepted.
    assert property (@(posedge clock) disable iff (!reset)
        (out_valid && !out_ready && !$isunknown(out_ready)) |=> (out_valid && $stable(out_index)));

    assert property (@(posedge clock) disable iff (!reset)
        hit_count <= HW'(COVER_WIDTH));

    assert property (@(posedge clock) disable iff (!reset)
        out_valid |-> (COVER_TOTAL == 0 || out_index < 64'(COVER_TOTAL)));

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed table-driven bench for cover_toggle_collector with COVER_WIDTH=4, COVER_INDEX=100.
module tb_cover_toggle_collector;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  valid;
    logic        clear;
    logic        out_ready;
    logic        out_valid;
    logic [63:0] out_index;
    logic [2:0]  hit_count;
    logic        all_covered;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    cover_toggle_collector #(
        .COVER_WIDTH(4),
        .COVER_INDEX(64'd100)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .valid      (valid),
        .clear      (clear),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_index  (out_index),
        .hit_count  (hit_count),
        .all_covered(all_covered)
    );

    typedef struct {
        logic [3:0]  vld;
        logic        clr;
        logic        rdy;
        logic        ev;
        logic [63:0] ei;
        logic [2:0]  eh;
        logic        ea;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] v, input logic c, input logic r,
                       input logic ev, input int ei, input int eh, input logic ea);
        vec_t t;
        t.vld = v;
        t.clr = c;
        t.rdy = r;
        t.ev  = ev;
        t.ei  = 64'(ei);
        t.eh  = 3'(eh);
        t.ea  = ea;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [63:0] ei,
                             input logic [2:0] eh, input logic ea);
        chk({tag, " out_valid"}, 64'(out_valid), 64'(ev));
        if (ev) chk({tag, " out_index"}, out_index, ei);
        chk({tag, " hit_count"}, 64'(hit_count), 64'(eh));
        chk({tag, " all_covered"}, 64'(all_covered), 64'(ea));
    endtask

    initial begin
        reset     = 1'b0;
        valid     = '0;
        clear     = 1'b0;
        out_ready = 1'b0;

        //   valid    clr  rdy  ev  idx  hc  all
        add(4'b0100, 0, 1, 1, 102, 1, 0);   // 1: single hit, latency 1
        add(4'b0000, 0, 1, 0,   0, 1, 0);   // 2: accepted, back to idle
        add(4'b1011, 0, 1, 1, 100, 4, 1);   // 3: ascending burst
        add(4'b0000, 0, 1, 1, 101, 4, 1);   // 4
        add(4'b0000, 0, 1, 1, 103, 4, 1);   // 5
        add(4'b0000, 0, 1, 0,   0, 4, 1);   // 6
        add(4'b0100, 0, 1, 0,   0, 4, 1);   // 7: already seen, not re-reported
        add(4'b0000, 1, 1, 0,   0, 0, 0);   // 8: clear
        add(4'b0001, 0, 0, 1, 100, 1, 0);   // 9: reported again after clear
        add(4'b0000, 0, 0, 1, 100, 1, 0);   // 10: stalled
        add(4'b0000, 0, 0, 1, 100, 1, 0);   // 11
        add(4'b0000, 0, 0, 1, 100, 1, 0);   // 12
        add(4'b0000, 0, 0, 1, 100, 1, 0);   // 13
        add(4'b0000, 0, 1, 0,   0, 1, 0);   // 14: first ready accepts
        add(4'b0001, 0, 1, 0,   0, 1, 0);   // 15: seen point ignored
        add(4'b1111, 1, 1, 0,   0, 0, 0);   // 16: clear beats valid
        add(4'b0000, 0, 1, 0,   0, 0, 0);   // 17
        add(4'b0110, 0, 0, 1, 101, 2, 0);   // 18
        add(4'b1001, 0, 0, 1, 101, 4, 1);   // 19: hits queue while stalled
        add(4'b0000, 0, 1, 1, 100, 4, 1);   // 20: lowest pending first
        add(4'b0000, 0, 1, 1, 102, 4, 1);   // 21
        add(4'b0000, 1, 0, 1, 102, 0, 0);   // 22: clear does not abort entry
        add(4'b0000, 0, 1, 0,   0, 0, 0);   // 23: 103 dropped by clear
        add(4'b1000, 0, 1, 1, 103, 1, 0);   // 24
        add(4'b0000, 0, 1, 0,   0, 1, 0);   // 25
        add(4'b0001, 0, 1, 1, 100, 2, 0);   // 26
        add(4'b0010, 0, 1, 1, 101, 3, 0);   // 27: new hit on handshake edge, no bubble
        add(4'b0000, 0, 1, 0,   0, 3, 0);   // 28

        #12;
        check_out("reset", 1'b0, 64'd0, 3'd0, 1'b0);
        chk("reset out_index", out_index, 64'd0);

        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            valid     = vecs[i].vld;
            clear     = vecs[i].clr;
            out_ready = vecs[i].rdy;
            @(posedge clock);
            #1;
            check_out($sformatf("row%0d", i + 1), vecs[i].ev, vecs[i].ei, vecs[i].eh, vecs[i].ea);
        end

        // Asynchronous reset while presenting 101 with 103 pending.
        valid     = '0;
        clear     = 1'b1;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        check_out("pre-clear", 1'b0, 64'd0, 3'd0, 1'b0);
        clear = 1'b0;
        valid = 4'b1010;
        @(posedge clock);
        #1;
        check_out("present101", 1'b1, 64'd101, 3'd2, 1'b0);
        valid = '0;
        #2;
        reset = 1'b0;
        valid = 4'b1111;
        #1;
        check_out("async reset", 1'b0, 64'd0, 3'd0, 1'b0);
        chk("async reset out_index", out_index, 64'd0);
        @(posedge clock);
        #1;
        check_out("held reset", 1'b0, 64'd0, 3'd0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            #1;
            check_out($sformatf("post-reset%0d", k), 1'b0, 64'd0, 3'd0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
